// File: rtl/adder_bist_driver.sv
// -----------------------------------------------------------------------------
// adder_bist_driver
//
// Purpose:
//   Stimulus/response self-test controller for a WIDTH-bit signed combinational
//   adder. Each run applies NUM_VECTORS operand pairs to the adder:
//     - vectors 0..3 are fixed corner cases,
//     - the remaining vectors come from a Galois LFSR.
//   Every returned sum/flag set is compared with a golden model. The block
//   reports pass/fail, a saturating error count and the index of the first
//   failing vector.
//
// Optional feature (macro ADDER_BIST_MISR_EN):
//   When the macro is defined, every sampled response is folded into a MISR,
//   which is presented on `signature`.
//   When the macro is undefined, there is no MISR logic and `signature` is 0.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset
//   start        in   1      begin a run (ignored while busy)
//   addend0      out  WIDTH  operand A to the adder (registered)
//   addend1      out  WIDTH  operand B to the adder (registered)
//   sum          in   WIDTH  adder result
//   Z, V, C, N   in   1 ea   adder flags (zero, overflow, carry, negative)
//   busy         out  1      run in progress
//   done         out  1      run finished; held until the next accepted start
//   pass         out  1      valid with done: 1 iff err_count == 0
//   err_count    out  16     mismatching vectors, saturates at 16'hFFFF
//   first_fail   out  16     index of the first mismatch, 16'hFFFF if none
//   signature    out  WIDTH  MISR result (0 when the MISR is not built)
//   dbg_state    out  2      current FSM state, for observation only
//
// Handshake:
//   `start` is sampled on each rising clock edge. It is accepted only in two
//   cases:
//     - in IDLE, or
//     - in DONE once `done` is high.
//   A start seen while `busy` is high is dropped and has no effect.
//   Once a run is accepted, `busy` stays high until the edge that raises
//   `done`. Both of these outputs change on that same edge.
// -----------------------------------------------------------------------------
module adder_bist_driver #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_VECTORS = 256,
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(32'hACE12468)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] addend0,
  output logic [WIDTH-1:0] addend1,
  input  logic [WIDTH-1:0] sum,
  input  logic             Z,
  input  logic             V,
  input  logic             C,
  input  logic             N,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail,
  output logic [WIDTH-1:0] signature,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Galois LFSR polynomial x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [WIDTH-1:0] TAPS    = WIDTH'(32'h8020_0003);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1    = '1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0]      NO_FAIL  = 16'hFFFF;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] addend0_q, addend1_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [15:0]      idx_q;
  logic [15:0]      err_q;
  logic [15:0]      first_fail_q;
  logic             busy_q, done_q, pass_q;

  // ---------------------------------------------------------------------------
  // Vector generation.
  // The LFSR advances by two steps on every CHECK, including the corner
  // vectors. Operand A is one step ahead of the current LFSR value and
  // operand B is two steps ahead.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lfsr_a, lfsr_b;
  logic [WIDTH-1:0] vec_a, vec_b;

  always_comb begin
    lfsr_a = lfsr_step(lfsr_q);
    lfsr_b = lfsr_step(lfsr_a);
    vec_a  = lfsr_a;
    vec_b  = lfsr_b;
    case (idx_q)
      16'd0: begin vec_a = ZERO;    vec_b = ZERO;    end
      16'd1: begin vec_a = MAX_POS; vec_b = ONE;     end
      16'd2: begin vec_a = ALL1;    vec_b = ONE;     end
      16'd3: begin vec_a = MIN_NEG; vec_b = MIN_NEG; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Golden model, evaluated on the operands currently held on the adder inputs.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   gold_full;
  logic [WIDTH-1:0] gold_sum;
  logic             gold_z, gold_v, gold_c, gold_n;
  logic             mismatch;

  always_comb begin
    gold_full = {1'b0, addend0_q} + {1'b0, addend1_q};
    gold_sum  = gold_full[WIDTH-1:0];
    gold_c    = gold_full[WIDTH];
    gold_n    = gold_sum[WIDTH-1];
    gold_z    = (gold_sum == ZERO);
    gold_v    = (addend0_q[WIDTH-1] == addend1_q[WIDTH-1]) &&
                (gold_sum[WIDTH-1] != addend0_q[WIDTH-1]);
    mismatch  = (sum != gold_sum) || (Z != gold_z) || (V != gold_v) ||
                (C != gold_c) || (N != gold_n);
  end

`ifdef ADDER_BIST_MISR_EN
  logic [WIDTH-1:0] misr_q;
  logic [WIDTH-1:0] misr_d;

  // The flags occupy the low four bits of the folded response word.
  always_comb begin
    misr_d = lfsr_step(misr_q) ^ (sum ^ {{(WIDTH-4){1'b0}}, Z, V, C, N});
  end
`endif

  // An accepted start can come from IDLE, or from DONE once it has been
  // finalized (done high). While DONE is still finalizing, busy is high.
  logic start_ok;
  assign start_ok = start && ((state_q == S_IDLE) ||
                              ((state_q == S_DONE) && done_q));

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addend0_q    <= '0;
      addend1_q    <= '0;
      lfsr_q       <= SEED;
      idx_q        <= '0;
      err_q        <= '0;
      first_fail_q <= NO_FAIL;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
`ifdef ADDER_BIST_MISR_EN
      misr_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state_q      <= S_APPLY;
            lfsr_q       <= SEED;
            idx_q        <= '0;
            err_q        <= '0;
            first_fail_q <= NO_FAIL;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef ADDER_BIST_MISR_EN
            misr_q       <= '0;
`endif
          end else if ((state_q == S_DONE) && !done_q) begin
            // This extra cycle lets the final CHECK's error update land
            // before pass is derived from err_count.
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            pass_q    <= (err_q == 16'd0);
            addend0_q <= '0;
            addend1_q <= '0;
          end
        end

        S_APPLY: begin
          // Drive the operands now; they settle through the adder for one full
          // cycle and are checked on the next edge.
          addend0_q <= vec_a;
          addend1_q <= vec_b;
          state_q   <= S_CHECK;
        end

        S_CHECK: begin
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (first_fail_q == NO_FAIL) first_fail_q <= idx_q;
          end
          lfsr_q <= lfsr_b;
          idx_q  <= idx_q + 16'd1;
`ifdef ADDER_BIST_MISR_EN
          misr_q <= misr_d;
`endif
          state_q <= (idx_q < LAST_IDX) ? S_APPLY : S_DONE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addend0    = addend0_q;
  assign addend1    = addend1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;
  assign dbg_state  = state_q;

`ifdef ADDER_BIST_MISR_EN
  assign signature = misr_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_adder_bist_driver.sv
// -----------------------------------------------------------------------------
// tb_adder_bist_driver
//
// Bench for adder_bist_driver with NUM_VECTORS = 16.
// A behavioural adder drives the DUT's sum/flag inputs. Its outputs can be
// faulted (a stuck sum bit, or a stuck flag). An array-based reference model
// recomputes the vector list and predicts the expected results:
// err_count, first_fail, pass and signature.
// -----------------------------------------------------------------------------
module tb_adder_bist_driver;

  localparam int          W    = 32;
  localparam int          NV   = 16;
  localparam logic [31:0] SEED = 32'hACE12468;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  logic start;
  always #5 clk = ~clk;

  logic [W-1:0] addend0, addend1, sum, signature;
  logic         Z, V, C, N, busy, done, pass;
  logic [15:0]  err_count, first_fail;
  logic [1:0]   dbg_state;

  adder_bist_driver #(.WIDTH(W), .NUM_VECTORS(NV), .SEED(SEED)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .addend0    (addend0),
    .addend1    (addend1),
    .sum        (sum),
    .Z          (Z),
    .V          (V),
    .C          (C),
    .N          (N),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .signature  (signature),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Adder under test (behavioural) with fault injection.
  // fault_mode: 0 none, 1 sum[fault_bit] stuck, 2 C stuck, 3 Z stuck,
  //             4 V stuck, 5 N stuck (stuck value = fault_val)
  // ---------------------------------------------------------------------------
  int       fault_mode;
  int       fault_bit;
  logic     fault_val;
  logic [W:0] adder_full;

  always_comb begin
    adder_full = {1'b0, addend0} + {1'b0, addend1};
    sum = adder_full[W-1:0];
    C   = adder_full[W];
    N   = adder_full[W-1];
    Z   = (adder_full[W-1:0] == '0);
    V   = (addend0[W-1] == addend1[W-1]) && (adder_full[W-1] != addend0[W-1]);
    case (fault_mode)
      1: sum[fault_bit] = fault_val;
      2: C = fault_val;
      3: Z = fault_val;
      4: V = fault_val;
      5: N = fault_val;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] va[NV];
  logic [W-1:0] vb[NV];

  function automatic logic [31:0] galois(input logic [31:0] s);
    logic [31:0] poly;
    poly = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  task automatic build_vectors();
    logic [31:0] l, a, b;
    l = SEED;
    for (int k = 0; k < NV; k++) begin
      a = galois(l);
      b = galois(a);
      l = b;
      va[k] = a;
      vb[k] = b;
    end
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000;
  endtask

  task automatic model(input int mode, input int bitn, input logic val,
                       output int err, output int ff, output logic [W-1:0] sig);
    longint unsigned ua, ub, us;
    longint          sa;
    logic [W-1:0]    s_true, s_obs;
    logic            z_t, v_t, c_t, n_t, z_o, v_o, c_o, n_o;
    err = 0;
    ff  = 16'hFFFF;
    sig = '0;
    for (int k = 0; k < NV; k++) begin
      ua = longint'(va[k]);
      ub = longint'(vb[k]);
      us = ua + ub;
      sa = longint'($signed(va[k])) + longint'($signed(vb[k]));
      s_true = us[W-1:0];
      c_t = (us >= 64'h1_0000_0000);
      z_t = (s_true == 0);
      n_t = (sa < 0) ? (sa >= -64'sd2147483648) : (sa > 64'sd2147483647);
      v_t = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
      s_obs = s_true; z_o = z_t; v_o = v_t; c_o = c_t; n_o = n_t;
      case (mode)
        1: s_obs[bitn] = val;
        2: c_o = val;
        3: z_o = val;
        4: v_o = val;
        5: n_o = val;
        default: ;
      endcase
      if (s_obs != s_true || z_o != z_t || v_o != v_t || c_o != c_t || n_o != n_t) begin
        if (err < 16'hFFFF) err++;
        if (ff == 16'hFFFF) ff = k;
      end
      sig = galois(sig) ^ s_obs ^ {28'd0, z_o, v_o, c_o, n_o};
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " addend0"},    addend0,    0);
    chk({tag, " addend1"},    addend1,    0);
    chk({tag, " busy"},       busy,       0);
    chk({tag, " done"},       done,       0);
    chk({tag, " pass"},       pass,       0);
    chk({tag, " err_count"},  err_count,  0);
    chk({tag, " first_fail"}, first_fail, 32'hFFFF);
    chk({tag, " signature"},  signature,  0);
  endtask

  // One full run. Extra start pulses land on cycle x1/x2 of the run; cycle 0 is
  // the edge that samples the accepted start.
  task automatic do_run(input string tag, input int x1, input int x2,
                        input int exp_err, input int exp_ff,
                        input logic exp_pass, input logic [W-1:0] exp_sig);
    int c;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy at accept"}, busy, 1);
    chk({tag, " done cleared"},   done, 0);
    c = 0;
    seen = 0;
    while (!seen && c < 2 * NV + 20) begin
      @(negedge clk);
      start = ((c + 1) == x1) || ((c + 1) == x2);
      tick();
      c++;
      if ((c % 2) == 1 && (c / 2) < NV) begin
        chk({tag, " addend0"}, addend0, va[c / 2]);
        chk({tag, " addend1"}, addend1, vb[c / 2]);
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, " done latency"}, c, 2 * NV + 1);
    chk({tag, " busy low"},     busy, 0);
    chk({tag, " pass"},         pass, exp_pass);
    chk({tag, " err_count"},    err_count, exp_err);
    chk({tag, " first_fail"},   first_fail, exp_ff);
    chk({tag, " signature"},    signature, exp_sig);
    chk({tag, " ops zero"},     addend0 | addend1, 0);
    tick();
    chk({tag, " done held"},    done, 1);
  endtask

  typedef struct {
    int   mode;
    int   bitn;
    logic val;
    logic exp_pass;
    int   exp_ff;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int           m_err, m_ff;
    logic [W-1:0] m_sig, e_sig;

    tbl[0] = '{0, 0,  1'b0, 1'b1, 16'hFFFF}; // correct adder
    tbl[1] = '{1, 0,  1'b1, 1'b0, 0};        // sum[0] stuck-at-1
    tbl[2] = '{2, 0,  1'b0, 1'b0, 2};        // C tied 0
    tbl[3] = '{1, 31, 1'b0, 1'b0, 1};        // sum[31] stuck-at-0
    tbl[4] = '{3, 0,  1'b0, 1'b0, 0};        // Z tied 0
    tbl[5] = '{4, 0,  1'b0, 1'b0, 1};        // V tied 0
    tbl[6] = '{5, 0,  1'b1, 1'b0, 0};        // N tied 1

    build_vectors();
    fault_mode = 0; fault_bit = 0; fault_val = 1'b0;
    reset_n = 1'b0;
    start   = 1'b1;  // start with reset low must be ignored
    repeat (3) tick();
    check_reset_values("reset");
    chk("reset state idle", dbg_state, 0);
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    tick();

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      fault_mode = tbl[i].mode;
      fault_bit  = tbl[i].bitn;
      fault_val  = tbl[i].val;
      model(tbl[i].mode, tbl[i].bitn, tbl[i].val, m_err, m_ff, m_sig);
`ifdef ADDER_BIST_MISR_EN
      e_sig = m_sig;
`else
      e_sig = '0;
`endif
      do_run($sformatf("tbl%0d", i), 0, 0, m_err, tbl[i].exp_ff, tbl[i].exp_pass, e_sig);
    end

    // Start re-pulsed mid-run: ignored, timing unchanged
    @(negedge clk);
    fault_mode = 0;
    model(0, 0, 1'b0, m_err, m_ff, m_sig);
`ifdef ADDER_BIST_MISR_EN
    e_sig = m_sig;
`else
    e_sig = '0;
`endif
    do_run("restart_ignored", 5, 20, m_err, m_ff, 1'b1, e_sig);

    // Reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("midrun busy", busy, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    tick();
    check_reset_values("midrun_reset_held");
    @(negedge clk);
    reset_n = 1'b1;
    do_run("after_reset", 0, 0, m_err, m_ff, 1'b1, e_sig);

    // Randomized faults and random ignored start pulses
    for (int r = 0; r < 6; r++) begin
      int md, bn, x1, x2;
      logic vl;
      md = $urandom_range(0, 5);
      bn = $urandom_range(0, W - 1);
      vl = 1'($urandom_range(0, 1));
      x1 = $urandom_range(1, 2 * NV);
      x2 = $urandom_range(1, 2 * NV);
      @(negedge clk);
      fault_mode = md;
      fault_bit  = bn;
      fault_val  = vl;
      model(md, bn, vl, m_err, m_ff, m_sig);
`ifdef ADDER_BIST_MISR_EN
      e_sig = m_sig;
`else
      e_sig = '0;
`endif
      do_run($sformatf("rand%0d_m%0d_b%0d_v%0d", r, md, bn, vl), x1, x2,
             m_err, m_ff, (m_err == 0), e_sig);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
